sd_fifo_rrarb: RTL and testbench

Round-robin, packet-aware arbiter that merges several srdy/drdy producer streams into one shared sd_fifo_c. It has a registered output stage. It throttles admission using the FIFO's `usage` output, so the shared FIFO never backs up into the holding register. It sits directly in front of the FIFO's `c_*` interface.

---
 rtl/sd_fifo_rrarb.sv | 185 ++++++++++++++++++
 tb/tb_sd_fifo_rrarb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_rrarb.sv
// ----------------------------------------------------------------------------
// sd_fifo_rrarb
//
// Round-robin, packet-aware arbiter that merges several srdy/drdy producer
// streams into one registered output stage feeding a shared sd_fifo_c.
// Once a stream wins with a non-eop word, it keeps the grant until its eop
// word is accepted. Admission is throttled by the downstream FIFO occupancy
// so the FIFO never backs up into the holding register.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous reset, active low
//   c_srdy   - per-stream source ready            [inputs]
//   c_data   - per-stream data, stream i at [i*width +: width]
//   c_eop    - per-stream end-of-packet, qualified by c_srdy
//   c_drdy   - per-stream accept, at most one bit set
//   p_srdy   - holding register valid
//   p_data   - holding register data
//   p_eop    - holding register eop
//   p_grant  - one-hot source of the held word (don't-care when p_srdy=0)
//   p_drdy   - downstream FIFO accept
//   usage    - downstream FIFO occupancy
// ----------------------------------------------------------------------------
module sd_fifo_rrarb #(
   parameter int inputs  = 4,
   parameter int width   = 8,
   parameter int usz     = 3,
   parameter int hiwater = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [inputs-1:0]         c_srdy,
   input  logic [inputs*width-1:0]   c_data,
   input  logic [inputs-1:0]         c_eop,
   output logic [inputs-1:0]         c_drdy,
   output logic                      p_srdy,
   output logic [width-1:0]          p_data,
   output logic                      p_eop,
   output logic [inputs-1:0]         p_grant,
   input  logic                      p_drdy,
   input  logic [usz-1:0]            usage
);

   localparam int pw  = (inputs > 1) ? $clog2(inputs) : 1;
   // One extra bit so pointer + offset never overflows before the wrap test.
   localparam int pw1 = pw + 1;
   localparam logic [usz-1:0] hiwater_u = usz'(hiwater);
   localparam logic [pw1-1:0] inputs_u  = pw1'(inputs);

   typedef enum logic {ST_ARB, ST_LOCK} state_t;

   state_t            state_reg, state_next;
   logic [pw-1:0]     ptr_reg, ptr_next;
   logic [pw-1:0]     lock_idx_reg, lock_idx_next;

   logic              p_srdy_reg;
   logic [width-1:0]  p_data_reg;
   logic              p_eop_reg;
   logic [inputs-1:0] p_grant_reg;

   logic [width-1:0]  data_arr [inputs];

   logic              load;
   logic              cand_found;
   logic [pw-1:0]     cand_idx;
   logic [pw-1:0]     sel_idx;
   logic              sel_valid;
   logic              sel_eop;
   logic [pw-1:0]     sel_inc;
   logic              capture;

   // Unpack the flat data bus into one word per stream.
   genvar gi;
   generate
      for (gi = 0; gi < inputs; gi++) begin : g_unpack
         assign data_arr[gi] = c_data[gi*width +: width];
      end
   endgenerate

   // The holding register can take a word when it is empty or draining this
   // cycle, and only while the FIFO is below the high-water mark.
   assign load = (!p_srdy_reg || p_drdy) && (usage < hiwater_u);

   // Rotating priority search: offset 0 from ptr has the highest priority.
   // Scanning offsets from high to low lets the lowest offset win last.
   always_comb begin
      logic [pw1-1:0] idx_ext;
      cand_found = 1'b0;
      cand_idx   = '0;
      idx_ext    = '0;
      for (int k = inputs - 1; k >= 0; k--) begin
         idx_ext = {1'b0, ptr_reg} + pw1'(k);
         if (idx_ext >= inputs_u)
            idx_ext = idx_ext - inputs_u;
         if (c_srdy[idx_ext[pw-1:0]]) begin
            cand_found = 1'b1;
            cand_idx   = idx_ext[pw-1:0];
         end
      end
   end

   // In LOCK only the locked stream is eligible; a gap on it is a bubble.
   assign sel_idx   = (state_reg == ST_LOCK) ? lock_idx_reg : cand_idx;
   assign sel_valid = (state_reg == ST_LOCK) ? c_srdy[lock_idx_reg] : cand_found;
   assign sel_eop   = c_eop[sel_idx];
   assign capture   = reset && load && sel_valid;

   always_comb begin
      logic [pw1-1:0] inc_ext;
      inc_ext = {1'b0, sel_idx} + pw1'(1);
      if (inc_ext >= inputs_u)
         inc_ext = '0;
      sel_inc = inc_ext[pw-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= ST_ARB;
         ptr_reg      <= '0;
         lock_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         lock_idx_reg <= lock_idx_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      lock_idx_next = lock_idx_reg;
      case (state_reg)
         ST_ARB: begin
            if (capture) begin
               if (sel_eop) begin
                  ptr_next = sel_inc;
               end else begin
                  state_next    = ST_LOCK;
                  lock_idx_next = sel_idx;
               end
            end
         end
         ST_LOCK: begin
            if (capture && sel_eop) begin
               state_next = ST_ARB;
               ptr_next   = sel_inc;
            end
         end
         default: state_next = ST_ARB;
      endcase
   end

   // Output logic: one-hot accept for the selected stream.
   always_comb begin
      c_drdy = '0;
      if (capture)
         c_drdy[sel_idx] = 1'b1;
   end

   // Holding register. A capture in the same cycle as a drain replaces the
   // word without a bubble; data/eop/grant hold when simply draining.
   always_ff @(posedge clk) begin
      if (!reset) begin
         p_srdy_reg  <= 1'b0;
         p_data_reg  <= '0;
         p_eop_reg   <= 1'b0;
         p_grant_reg <= '0;
      end else if (capture) begin
         p_srdy_reg  <= 1'b1;
         p_data_reg  <= data_arr[sel_idx];
         p_eop_reg   <= sel_eop;
         p_grant_reg <= c_drdy;
      end else if (p_drdy) begin
         p_srdy_reg  <= 1'b0;
      end
   end

   assign p_srdy  = p_srdy_reg;
   assign p_data  = p_data_reg;
   assign p_eop   = p_eop_reg;
   assign p_grant = p_grant_reg;

endmodule

// File: tb/tb_sd_fifo_rrarb.sv
// ----------------------------------------------------------------------------
// tb_sd_fifo_rrarb
//
// Directed bench for sd_fifo_rrarb (4 streams, width 8, hiwater 5) followed
// by a random soak through a depth-7 FIFO occupancy model with per-stream
// ordering and packet-interleave checks.
// ----------------------------------------------------------------------------
module tb_sd_fifo_rrarb;

   localparam int inputs  = 4;
   localparam int width   = 8;
   localparam int usz     = 3;
   localparam int hiwater = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [inputs-1:0]       c_srdy;
   logic [inputs*width-1:0] c_data;
   logic [inputs-1:0]       c_eop;
   logic [inputs-1:0]       c_drdy;
   logic                    p_srdy;
   logic [width-1:0]        p_data;
   logic                    p_eop;
   logic [inputs-1:0]       p_grant;
   logic                    p_drdy;
   logic [usz-1:0]          usage;

   int checks   = 0;
   int failures = 0;

   sd_fifo_rrarb #(
      .inputs  (inputs),
      .width   (width),
      .usz     (usz),
      .hiwater (hiwater)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .c_srdy  (c_srdy),
      .c_data  (c_data),
      .c_eop   (c_eop),
      .c_drdy  (c_drdy),
      .p_srdy  (p_srdy),
      .p_data  (p_data),
      .p_eop   (p_eop),
      .p_grant (p_grant),
      .p_drdy  (p_drdy),
      .usage   (usage)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_data(input int s, input logic [7:0] d);
      c_data[s*width +: width] = d;
   endtask

   // Inputs are already applied at posedge+1; check the combinational accept
   // a little later, then advance to just after the next rising edge.
   task automatic drive_cycle(input string tag, input logic [3:0] exp_drdy);
      #1;
      check_val({tag, "_c_drdy"}, 32'(c_drdy), 32'(exp_drdy));
      @(posedge clk);
      #1;
   endtask

   task automatic check_hold(input string tag, input logic exp_srdy, input logic [7:0] exp_data,
                             input logic exp_eop, input logic [3:0] exp_grant);
      $display("tx %s srdy=%0b data=%02h eop=%0b grant=%04b", tag, p_srdy, p_data, p_eop, p_grant);
      check_val({tag, "_p_srdy"},  32'(p_srdy),  32'(exp_srdy));
      check_val({tag, "_p_data"},  32'(p_data),  32'(exp_data));
      check_val({tag, "_p_eop"},   32'(p_eop),   32'(exp_eop));
      check_val({tag, "_p_grant"}, 32'(p_grant), 32'(exp_grant));
   endtask

   // Soak state
   logic [5:0]        src_seq [inputs];
   logic [5:0]        exp_seq [inputs];
   int                rem     [inputs];
   int                size;
   int                open_s;
   int                words;
   int                overflow;
   int                s;
   logic              pop;
   logic              push;
   logic [inputs-1:0] acc;

   initial begin
      reset  = 1'b0;
      c_srdy = 4'hf;
      c_eop  = 4'h0;
      p_drdy = 1'b1;
      usage  = '0;
      for (int i = 0; i < inputs; i++) set_data(i, 8'(8'hA0 + i));

      // Reset state, with all streams requesting.
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_c_drdy", 32'(c_drdy), 32'h0);
      check_hold("reset", 1'b0, 8'h00, 1'b0, 4'b0000);

      // 1: round robin, single-word packets on every stream.
      reset = 1'b1;
      c_eop = 4'hf;
      for (int k = 0; k < 8; k++) begin
         drive_cycle("rr", 4'(1 << (k % 4)));
         check_hold("rr", 1'b1, 8'(8'hA0 + (k % 4)), 1'b1, 4'(1 << (k % 4)));
      end

      // 2: packet lock on stream 2 with a mid-packet gap; stream 0 waits.
      c_srdy = 4'b0100; c_eop = 4'b0000; set_data(2, 8'h21);
      drive_cycle("lock_w1", 4'b0100);
      check_hold("lock_w1", 1'b1, 8'h21, 1'b0, 4'b0100);
      c_srdy = 4'b0101; set_data(2, 8'h22);
      drive_cycle("lock_w2", 4'b0100);
      check_hold("lock_w2", 1'b1, 8'h22, 1'b0, 4'b0100);
      c_srdy = 4'b0001;
      drive_cycle("lock_gap", 4'b0000);
      check_hold("lock_gap", 1'b0, 8'h22, 1'b0, 4'b0100);
      c_srdy = 4'b0101; c_eop = 4'b0100; set_data(2, 8'h23);
      drive_cycle("lock_w3", 4'b0100);
      check_hold("lock_w3", 1'b1, 8'h23, 1'b1, 4'b0100);
      c_srdy = 4'b0001; c_eop = 4'b0001;
      drive_cycle("lock_s0", 4'b0001);
      check_hold("lock_s0", 1'b1, 8'hA0, 1'b1, 4'b0001);
      c_srdy = 4'b0000;
      drive_cycle("idle", 4'b0000);
      check_hold("idle", 1'b0, 8'hA0, 1'b1, 4'b0001);

      // 3: backpressure, ptr now at stream 1.
      set_data(2, 8'hA2);
      c_srdy = 4'hf; c_eop = 4'hf; p_drdy = 1'b0;
      drive_cycle("bp_load", 4'b0010);
      check_hold("bp_load", 1'b1, 8'hA1, 1'b1, 4'b0010);
      for (int k = 0; k < 4; k++) begin
         drive_cycle("bp_hold", 4'b0000);
         check_hold("bp_hold", 1'b1, 8'hA1, 1'b1, 4'b0010);
      end
      p_drdy = 1'b1;
      drive_cycle("bp_release", 4'b0100);
      check_hold("bp_release", 1'b1, 8'hA2, 1'b1, 4'b0100);

      // 4: throttle at usage == hiwater, drain, then resume at hiwater-1.
      usage  = 3'd5;
      p_drdy = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) p_drdy = 1'b1;
         drive_cycle("thr", 4'b0000);
         check_hold("thr", (k < 3), 8'hA2, 1'b1, 4'b0100);
      end
      usage = 3'd4;
      drive_cycle("thr_resume", 4'b1000);
      check_hold("thr_resume", 1'b1, 8'hA3, 1'b1, 4'b1000);
      usage = 3'd0;

      // 5: lock on stream 3, retained across throttle, then reset mid-packet.
      c_srdy = 4'b1000; c_eop = 4'b0000; set_data(3, 8'h31);
      drive_cycle("rst_w1", 4'b1000);
      check_hold("rst_w1", 1'b1, 8'h31, 1'b0, 4'b1000);
      usage = 3'd5; c_srdy = 4'hf;
      drive_cycle("rst_thr", 4'b0000);
      check_hold("rst_thr", 1'b0, 8'h31, 1'b0, 4'b1000);
      usage = 3'd0; c_srdy = 4'b1001; set_data(3, 8'h32);
      drive_cycle("rst_w2", 4'b1000);
      check_hold("rst_w2", 1'b1, 8'h32, 1'b0, 4'b1000);
      reset = 1'b0; c_srdy = 4'hf;
      drive_cycle("rst_assert", 4'b0000);
      check_hold("rst_assert", 1'b0, 8'h00, 1'b0, 4'b0000);
      reset = 1'b1; c_srdy = 4'b1010; c_eop = 4'hf;
      drive_cycle("rst_release", 4'b0010);
      check_hold("rst_release", 1'b1, 8'hA1, 1'b1, 4'b0010);
      c_srdy = 4'b0000;
      drive_cycle("pre_soak", 4'b0000);
      check_hold("pre_soak", 1'b0, 8'hA1, 1'b1, 4'b0010);

      // 6: random soak against a depth-7 FIFO occupancy model.
      size = 0; open_s = -1; words = 0; overflow = 0;
      for (int i = 0; i < inputs; i++) begin
         src_seq[i] = '0;
         exp_seq[i] = '0;
         rem[i]     = int'($urandom_range(1, 4));
      end
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < inputs; i++) begin
            c_srdy[i] = ($urandom_range(0, 3) != 0);
            set_data(i, {2'(i), src_seq[i]});
            c_eop[i]  = (rem[i] == 1);
         end
         usage  = usz'(size);
         p_drdy = (size < 7);
         pop    = (size > 0) && ($urandom_range(0, 3) != 0);
         #1;
         acc  = c_srdy & c_drdy;
         push = p_srdy && p_drdy;
         if (p_srdy && size == 7) overflow++;
         if (push) begin
            s = 0;
            for (int i = inputs - 1; i >= 0; i--) if (p_grant[i]) s = i;
            $display("tx soak stream=%0d data=%02h eop=%0b", s, p_data, p_eop);
            check_val("soak_onehot", 32'($countones(p_grant)), 32'd1);
            check_val("soak_data", 32'(p_data), 32'({2'(s), exp_seq[s]}));
            if (open_s >= 0) check_val("soak_interleave", 32'(s), 32'(open_s));
            open_s = p_eop ? -1 : s;
            exp_seq[s] = exp_seq[s] + 6'd1;
            words++;
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < inputs; i++) begin
            if (acc[i]) begin
               src_seq[i] = src_seq[i] + 6'd1;
               rem[i]     = rem[i] - 1;
               if (rem[i] == 0) rem[i] = int'($urandom_range(1, 4));
            end
         end
         size = size + int'(push) - int'(pop);
      end
      check_val("soak_overflow", 32'(overflow), 32'd0);
      check_val("soak_words_ge_1000", 32'(words >= 1000), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
